// File: rtl/pll_phase_ctrl.sv
// PLL reset/lock sequencer and dynamic phase-shift controller with per-output phase tracking.
// Optional build macro PLL_LOCK_LOSS_CNT_EN adds a saturating 16-bit lock-loss event counter.
module pll_phase_ctrl #(
    parameter int NUM_OUT   = 5,
    parameter int STEP_W    = 8,
    parameter int PHASE_W   = 10,
    parameter int RST_LEN   = 16,
    parameter int LOCK_WAIT = 1024,
    parameter int PULSE_LEN = 2,
    parameter int GAP_LEN   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       restart,
    input  logic                       pll_lock,
    output logic                       pll_rst,
    output logic [2:0]                 phase_sel,
    output logic                       phase_dir,
    output logic                       phase_step_n,
    output logic                       load_phase,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [2:0]                 req_sel,
    input  logic                       req_dir,
    input  logic [STEP_W-1:0]          req_steps,
    output logic                       done,
    output logic                       err_sel,
    output logic                       locked,
    output logic                       lock_lost,
    output logic [NUM_OUT*PHASE_W-1:0] phase_pos
`ifdef PLL_LOCK_LOSS_CNT_EN
    ,
    output logic [15:0]                lock_loss_cnt
`endif
);

    localparam int CNT_MAX_A = (RST_LEN > LOCK_WAIT) ? RST_LEN : LOCK_WAIT;
    localparam int CNT_MAX_B = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int CNT_MAX   = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_LEN - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_WAIT - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_LEN - 1);
    localparam logic [2:0]       SEL_LIMIT  = 3'(NUM_OUT);

    typedef enum logic [2:0] {
        S_RST,
        S_WAIT_LOCK,
        S_IDLE,
        S_STEP_LO,
        S_STEP_HI,
        S_LOAD,
        S_DONE
    } state_e;

    state_e                           state_q, state_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [STEP_W-1:0]                rem_q, rem_d;
    logic [2:0]                       sel_q, sel_d;
    logic                             dir_q, dir_d;
    logic                             err_q, err_d;
    logic [NUM_OUT-1:0][PHASE_W-1:0]  pos_q, pos_d;

    logic locked_st;
    logic lost;
    logic ready_w;
    logic accept;

    assign locked_st = (state_q == S_IDLE) || (state_q == S_STEP_LO) || (state_q == S_STEP_HI)
                    || (state_q == S_LOAD) || (state_q == S_DONE);
    assign lost      = locked_st && !pll_lock;
    // Withhold ready when this cycle is leaving IDLE anyway, so no handshake is lost.
    assign ready_w   = (state_q == S_IDLE) && !restart && pll_lock;
    assign accept    = req_valid && ready_w;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        sel_d   = sel_q;
        dir_d   = dir_q;
        pos_d   = pos_q;
        err_d   = 1'b0;

        case (state_q)
            S_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                if (!pll_lock) begin
                    cnt_d = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (accept) begin
                    if (req_sel >= SEL_LIMIT) begin
                        err_d = 1'b1;
                    end else begin
                        sel_d = req_sel;
                        dir_d = req_dir;
                        cnt_d = '0;
                        rem_d = req_steps;
                        state_d = (req_steps == '0) ? S_LOAD : S_STEP_LO;
                    end
                end
            end
            S_STEP_LO: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = S_STEP_HI;
                    cnt_d   = '0;
                    for (int k = 0; k < NUM_OUT; k++) begin
                        if (sel_q == 3'(k)) begin
                            pos_d[k] = dir_q ? pos_q[k] + PHASE_W'(1) : pos_q[k] - PHASE_W'(1);
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STEP_HI: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    rem_d   = rem_q - 1'b1;
                    state_d = (rem_q == STEP_W'(1)) ? S_LOAD : S_STEP_LO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LOAD:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: begin
                state_d = S_RST;
                cnt_d   = '0;
            end
        endcase

        if (lost || restart) begin
            state_d = S_RST;
            cnt_d   = '0;
        end

        // A PLL reset restores the static phases, so tracking restarts from zero.
        if (state_d == S_RST) begin
            pos_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_RST;
            cnt_q   <= '0;
            rem_q   <= '0;
            sel_q   <= '0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            sel_q   <= sel_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
            pos_q   <= pos_d;
        end
    end

`ifdef PLL_LOCK_LOSS_CNT_EN
    logic [15:0] llc_q, llc_d;

    always_comb begin
        llc_d = llc_q;
        if (lost && (llc_q != 16'hFFFF)) begin
            llc_d = llc_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            llc_q <= '0;
        end else begin
            llc_q <= llc_d;
        end
    end

    assign lock_loss_cnt = llc_q;
`endif

    // Step/load/done strobes are cut in the same cycle lock is seen to drop.
    assign pll_rst      = (state_q == S_RST);
    assign phase_step_n = !((state_q == S_STEP_LO) && !lost);
    assign load_phase   = (state_q == S_LOAD) && !lost;
    assign done         = (state_q == S_DONE) && !lost;
    assign phase_sel    = sel_q;
    assign phase_dir    = dir_q;
    assign req_ready    = ready_w;
    assign err_sel      = err_q;
    assign locked       = locked_st;
    assign lock_lost    = lost;
    assign phase_pos    = pos_q;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Directed bench for pll_phase_ctrl: reset/lock timing, a table of phase requests,
// and hand-written lock-loss, lock-glitch and restart sequences.
module tb_pll_phase_ctrl;

    localparam int NOUT = 5;
    localparam int PW   = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              restart;
    logic              pll_lock;
    logic              pll_rst;
    logic [2:0]        phase_sel;
    logic              phase_dir;
    logic              phase_step_n;
    logic              load_phase;
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_sel;
    logic              req_dir;
    logic [7:0]        req_steps;
    logic              done;
    logic              err_sel;
    logic              locked;
    logic              lock_lost;
    logic [NOUT*PW-1:0] phase_pos;
`ifdef PLL_LOCK_LOSS_CNT_EN
    logic [15:0]       lock_loss_cnt;
`endif

    pll_phase_ctrl dut (
        .clk(clk), .rst_n(rst_n), .restart(restart), .pll_lock(pll_lock),
        .pll_rst(pll_rst), .phase_sel(phase_sel), .phase_dir(phase_dir),
        .phase_step_n(phase_step_n), .load_phase(load_phase),
        .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
        .req_dir(req_dir), .req_steps(req_steps), .done(done), .err_sel(err_sel),
        .locked(locked), .lock_lost(lock_lost), .phase_pos(phase_pos)
`ifdef PLL_LOCK_LOSS_CNT_EN
        , .lock_loss_cnt(lock_loss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        int sel;
        int dir;
        int steps;
        bit bad;
        int lat;
        int ch;
        int pos;
    } vec_t;

    vec_t vt[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pos_of(input int ch);
        return 32'(phase_pos[ch*PW +: PW]);
    endfunction

    int n, m, lat, lows, loads, errs, falls;
    logic prev;

    initial begin
        vt[0] = '{sel:2, dir:1, steps:3,   bad:0, lat:20,   ch:2, pos:3};
        vt[1] = '{sel:0, dir:0, steps:1,   bad:0, lat:8,    ch:0, pos:1023};
        vt[2] = '{sel:5, dir:1, steps:4,   bad:1, lat:0,    ch:2, pos:3};
        vt[3] = '{sel:4, dir:1, steps:0,   bad:0, lat:2,    ch:4, pos:0};
        vt[4] = '{sel:2, dir:0, steps:2,   bad:0, lat:14,   ch:2, pos:1};
        vt[5] = '{sel:7, dir:0, steps:1,   bad:1, lat:0,    ch:0, pos:1023};
        vt[6] = '{sel:0, dir:1, steps:2,   bad:0, lat:14,   ch:0, pos:1};
        vt[7] = '{sel:1, dir:1, steps:255, bad:0, lat:1532, ch:1, pos:255};

        rst_n = 1'b0; restart = 1'b0; pll_lock = 1'b1;
        req_valid = 1'b0; req_sel = '0; req_dir = 1'b0; req_steps = '0;
        repeat (3) tick();

        chk("rst_pll_rst", 32'(pll_rst), 1);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_step_n", 32'(phase_step_n), 1);
        chk("rst_load", 32'(load_phase), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pos_zero", 32'(phase_pos == '0), 1);
`ifdef PLL_LOCK_LOSS_CNT_EN
        chk("rst_llc", 32'(lock_loss_cnt), 0);
`endif

        rst_n = 1'b1;
        n = 0;
        while (pll_rst && n < 100) begin n++; tick(); end
        chk("rst_len", n, 16);
        m = 0;
        while (!locked && m < 2000) begin m++; tick(); end
        chk("lock_wait", m, 1024);
        chk("ready_after_lock", 32'(req_ready), 1);

        for (int i = 0; i < 8; i++) begin
            chk("ready_pre", 32'(req_ready), 1);
            req_valid = 1'b1;
            req_sel   = 3'(vt[i].sel);
            req_dir   = vt[i].dir[0];
            req_steps = 8'(vt[i].steps);
            tick();
            req_valid = 1'b0;
            lat = 0; lows = 0; loads = 0; errs = 0;
            for (int k = 1; k <= 2000; k++) begin
                if (k == 1) begin
                    chk("err_pulse", 32'(err_sel), 32'(vt[i].bad));
                    if (vt[i].bad) chk("ready_on_err", 32'(req_ready), 1);
                    else           chk("phase_sel_latched", 32'(phase_sel), 32'(vt[i].sel));
                end
                if (!phase_step_n) lows++;
                if (load_phase) loads++;
                if (err_sel) errs++;
                if (done) begin lat = k; break; end
                if (vt[i].bad && k == 10) break;
                tick();
            end
            if (vt[i].bad) begin
                chk("bad_no_done", lat, 0);
                chk("bad_no_steps", lows, 0);
                chk("bad_err_count", errs, 1);
            end else begin
                chk("done_latency", lat, vt[i].lat);
                chk("step_low_cycles", lows, vt[i].steps * 2);
                chk("load_cycles", loads, 1);
            end
            chk("phase_pos", pos_of(vt[i].ch), vt[i].pos);
            tick();
        end

        // Lock drops on the first cycle of the second step of a 5-step request.
        req_valid = 1'b1; req_sel = 3'd3; req_dir = 1'b1; req_steps = 8'd5;
        tick();
        req_valid = 1'b0;
        falls = 0; prev = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (!phase_step_n && prev) falls++;
            prev = phase_step_n;
            if (falls == 2) break;
            tick();
        end
        chk("ll_second_step", falls, 2);
        chk("ll_pos_before", pos_of(3), 1);
        pll_lock = 1'b0;
        #1;
        chk("ll_pulse", 32'(lock_lost), 1);
        chk("ll_step_forced_hi", 32'(phase_step_n), 1);
        chk("ll_no_done", 32'(done), 0);
        tick();
        chk("ll_pulse_once", 32'(lock_lost), 0);
        chk("ll_locked_drop", 32'(locked), 0);
        chk("ll_pll_rst", 32'(pll_rst), 1);
        chk("ll_pos_cleared", 32'(phase_pos == '0), 1);
        chk("ll_step_idle", 32'(phase_step_n), 1);
`ifdef PLL_LOCK_LOSS_CNT_EN
        chk("ll_cnt", 32'(lock_loss_cnt), 1);
`endif
        pll_lock = 1'b1;
        n = 0;
        while (pll_rst && n < 100) begin n++; tick(); end
        chk("ll_rst_len", n, 16);

        // A one-cycle lock glitch in WAIT_LOCK restarts the qualification count.
        m = 0;
        while (!locked && m < 500) begin m++; tick(); end
        chk("glitch_not_locked", 32'(locked), 0);
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        m = 0;
        while (!locked && m < 2000) begin m++; tick(); end
        chk("glitch_relock", m, 1024);

        // Restart and a request in the same IDLE cycle: restart wins.
        restart = 1'b1;
        req_valid = 1'b1; req_sel = 3'd1; req_dir = 1'b1; req_steps = 8'd1;
        tick();
        restart = 1'b0;
        req_valid = 1'b0;
        chk("rs_locked_drop", 32'(locked), 0);
        chk("rs_pll_rst", 32'(pll_rst), 1);
        chk("rs_no_err", 32'(err_sel), 0);
        chk("rs_no_step", 32'(phase_step_n), 1);
        chk("rs_no_lock_lost", 32'(lock_lost), 0);
        n = 0;
        while (pll_rst && n < 100) begin n++; tick(); end
        chk("rs_rst_len", n, 16);
        m = 0;
        while (!locked && m < 2000) begin m++; tick(); end
        chk("rs_relock", m, 1024);
        chk("rs_pos_untouched", pos_of(1), 0);
`ifdef PLL_LOCK_LOSS_CNT_EN
        chk("rs_cnt_kept", 32'(lock_loss_cnt), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
